// File: rtl/spi_slave_target.sv
// SPI mode-0 target, MSB first, 8-bit frames, oversampled on HCLK.
// TX holding register with valid/ready, pulsed RX byte, sticky underrun flag.
//
// state  | meaning
// IDLE   | not selected, MISO driven 0, waiting for SS
// ACTIVE | selected, shifting bytes on synchronised SCLK edges
module spi_slave_target #(
    parameter int          SYNC_STAGES     = 2,
    parameter bit          SS_ACTIVE_HIGH  = 1'b0,
    parameter logic [7:0]  DEFAULT_TX_BYTE = 8'hFF
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       SPI_CLK_i,
    input  logic       SPI_MOSI_i,
    input  logic       SPI_SS_i,
    output logic       SPI_MISO_o,
    output logic       SPI_MISO_OE_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       selected_o,
    output logic       frame_done_o,
    output logic       tx_underrun_o,
    input  logic       underrun_clr_i
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    localparam logic SS_IDLE_LVL = SS_ACTIVE_HIGH ? 1'b0 : 1'b1;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
    logic       sclk_s, sclk_d, mosi_s, ss_act;
    logic       sclk_rise, sclk_fall;

    logic [2:0] bit_cnt;
    logic       byte_started;
    logic [6:0] rx_shift;
    logic [7:0] tx_shift;
    logic [7:0] hold_data;
    logic       hold_full;

    logic       enter, leave, load, rx_step, tx_step, wr;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= {SYNC_STAGES{SS_IDLE_LVL}};
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_CLK_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI_i};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SPI_SS_i};
            sclk_d    <= sclk_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign ss_act    = SS_ACTIVE_HIGH ? ss_sync[SYNC_STAGES-1] : ~ss_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign wr        = tx_valid_i & ~hold_full;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // SS deassertion wins over any edge seen in the same cycle
    always_comb begin
        state_d = state_q;
        enter   = 1'b0;
        leave   = 1'b0;
        load    = 1'b0;
        rx_step = 1'b0;
        tx_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_act) begin
                    state_d = ACTIVE;
                    enter   = 1'b1;
                    load    = 1'b1;
                end
            end
            ACTIVE: begin
                if (!ss_act) begin
                    state_d = IDLE;
                    leave   = 1'b1;
                end else begin
                    rx_step = sclk_rise;
                    if (sclk_fall && byte_started) begin
                        if (bit_cnt == 3'd0) load    = 1'b1;
                        else                 tx_step = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            bit_cnt       <= 3'd0;
            byte_started  <= 1'b0;
            rx_shift      <= '0;
            tx_shift      <= '0;
            rx_data_o     <= '0;
            rx_valid_o    <= 1'b0;
            frame_done_o  <= 1'b0;
            hold_data     <= '0;
            hold_full     <= 1'b0;
            tx_underrun_o <= 1'b0;
        end else begin
            rx_valid_o   <= 1'b0;
            frame_done_o <= leave;

            if (enter || leave) begin
                bit_cnt      <= 3'd0;
                byte_started <= 1'b0;
            end

            if (rx_step) begin
                rx_shift     <= {rx_shift[5:0], mosi_s};
                bit_cnt      <= bit_cnt + 3'd1;
                byte_started <= 1'b1;
                if (bit_cnt == 3'd7) begin
                    rx_data_o  <= {rx_shift, mosi_s};
                    rx_valid_o <= 1'b1;
                end
            end

            if (load)         tx_shift <= hold_full ? hold_data : DEFAULT_TX_BYTE;
            else if (tx_step) tx_shift <= {tx_shift[6:0], 1'b0};

            // A write into an empty register during a load is kept for the next load
            if (load && hold_full) begin
                hold_full <= 1'b0;
            end else if (wr) begin
                hold_full <= 1'b1;
                hold_data <= tx_data_i;
            end

            if (load && !hold_full) tx_underrun_o <= 1'b1;
            else if (underrun_clr_i) tx_underrun_o <= 1'b0;
        end
    end

    assign selected_o    = (state_q == ACTIVE);
    assign SPI_MISO_OE_o = selected_o;
    assign SPI_MISO_o    = selected_o & tx_shift[7];
    assign tx_ready_o    = ~hold_full;

endmodule

// File: tb/tb_spi_slave_target.sv
// Bench for spi_slave_target: bit-banged SPI master, RX scoreboard queue,
// per-byte MISO comparison and frame/underrun/reset checks.
module tb_spi_slave_target;

    localparam int HALF = 8;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic       SPI_CLK_i, SPI_MOSI_i, SPI_SS_i;
    logic       SPI_MISO_o, SPI_MISO_OE_o;
    logic [7:0] tx_data_i;
    logic       tx_valid_i, tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o, selected_o, frame_done_o, tx_underrun_o;
    logic       underrun_clr_i;

    int n_checks = 0;
    int n_fail   = 0;
    int rx_cnt   = 0;
    int fd_cnt   = 0;
    int fd0, rx0;
    logic       rxv_prev = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] miso_q[$];
    logic [7:0] junk;

    always #5 HCLK = ~HCLK;

    spi_slave_target dut (
        .HCLK           (HCLK),
        .HRESETn        (HRESETn),
        .SPI_CLK_i      (SPI_CLK_i),
        .SPI_MOSI_i     (SPI_MOSI_i),
        .SPI_SS_i       (SPI_SS_i),
        .SPI_MISO_o     (SPI_MISO_o),
        .SPI_MISO_OE_o  (SPI_MISO_OE_o),
        .tx_data_i      (tx_data_i),
        .tx_valid_i     (tx_valid_i),
        .tx_ready_o     (tx_ready_o),
        .rx_data_o      (rx_data_o),
        .rx_valid_o     (rx_valid_o),
        .selected_o     (selected_o),
        .frame_done_o   (frame_done_o),
        .tx_underrun_o  (tx_underrun_o),
        .underrun_clr_i (underrun_clr_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge HCLK) begin
        if (rx_valid_o) begin
            rx_cnt++;
            chk("rx_pulse_width", {31'd0, rxv_prev}, 32'd0);
            if (rx_q.size() == 0) chk("rx_unexpected", 32'd1, 32'd0);
            else                  chk("rx_data", {24'd0, rx_data_o}, {24'd0, rx_q.pop_front()});
        end
        if (frame_done_o) fd_cnt++;
        rxv_prev = rx_valid_o;
    end

    task automatic clk_n(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic ss_on();
        SPI_SS_i = 1'b0;
        clk_n(HALF);
    endtask

    task automatic ss_off();
        SPI_SS_i = 1'b1;
        clk_n(HALF);
    endtask

    task automatic spi_bits(input logic [7:0] mosi_b, input int nbits, output logic [7:0] miso_b);
        miso_b = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            SPI_MOSI_i = mosi_b[7-i];
            clk_n(HALF);
            SPI_CLK_i = 1'b1;
            miso_b    = {miso_b[6:0], SPI_MISO_o};
            clk_n(HALF);
            SPI_CLK_i = 1'b0;
        end
        clk_n(HALF);
    endtask

    task automatic spi_byte(input logic [7:0] mosi_b, input logic [7:0] miso_exp);
        logic [7:0] got;
        rx_q.push_back(mosi_b);
        miso_q.push_back(miso_exp);
        spi_bits(mosi_b, 8, got);
        chk("miso_byte", {24'd0, got}, {24'd0, miso_q.pop_front()});
    endtask

    task automatic tx_write(input logic [7:0] d);
        int k = 0;
        while (!tx_ready_o && k < 100) begin
            clk_n(1);
            k++;
        end
        chk("tx_ready_wait", {31'd0, tx_ready_o}, 32'd1);
        tx_data_i  = d;
        tx_valid_i = 1'b1;
        clk_n(1);
        tx_valid_i = 1'b0;
    endtask

    task automatic clr_pulse();
        underrun_clr_i = 1'b1;
        clk_n(1);
        underrun_clr_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal;
    end

    initial begin
        HRESETn = 1'b0; SPI_CLK_i = 1'b0; SPI_MOSI_i = 1'b0; SPI_SS_i = 1'b1;
        tx_data_i = 8'h00; tx_valid_i = 1'b0; underrun_clr_i = 1'b0;
        clk_n(3);
        chk("rst_tx_ready", {31'd0, tx_ready_o}, 32'd1);
        chk("rst_rx_valid", {31'd0, rx_valid_o}, 32'd0);
        chk("rst_miso", {31'd0, SPI_MISO_o}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data_o}, 32'd0);
        chk("rst_underrun", {31'd0, tx_underrun_o}, 32'd0);
        HRESETn = 1'b1;
        clk_n(2);

        // single byte with preloaded TX
        tx_write(8'hA5);
        chk("t1_ready_full", {31'd0, tx_ready_o}, 32'd0);
        ss_on();
        chk("t1_ready_after_ss", {31'd0, tx_ready_o}, 32'd1);
        chk("t1_selected", {31'd0, selected_o}, 32'd1);
        chk("t1_oe", {31'd0, SPI_MISO_OE_o}, 32'd1);
        spi_byte(8'h3C, 8'hA5);
        fd0 = fd_cnt;
        ss_off();
        chk("t1_frame_done", fd_cnt - fd0, 32'd1);
        chk("t1_deselected", {31'd0, selected_o}, 32'd0);
        chk("t1_miso_idle", {31'd0, SPI_MISO_o}, 32'd0);
        chk("t1_rx_count", rx_cnt, 32'd1);

        // two-byte frame, second byte written after first consume
        tx_write(8'h12);
        ss_on();
        tx_write(8'h34);
        spi_byte(8'hDE, 8'h12);
        spi_byte(8'hAD, 8'h34);
        fd0 = fd_cnt;
        ss_off();
        chk("t2_frame_done", fd_cnt - fd0, 32'd1);
        chk("t2_rx_count", rx_cnt, 32'd3);

        // underrun with empty holding register
        clr_pulse();
        chk("t3_underrun_cleared", {31'd0, tx_underrun_o}, 32'd0);
        ss_on();
        chk("t3_underrun_set", {31'd0, tx_underrun_o}, 32'd1);
        spi_byte(8'h77, 8'hFF);
        ss_off();
        chk("t3_underrun_sticky", {31'd0, tx_underrun_o}, 32'd1);
        clr_pulse();
        chk("t3_underrun_clr", {31'd0, tx_underrun_o}, 32'd0);

        // aborted partial byte, then a clean byte
        ss_on();
        spi_bits(8'hF0, 5, junk);
        fd0 = fd_cnt;
        rx0 = rx_cnt;
        ss_off();
        chk("t4_no_rx_valid", rx_cnt - rx0, 32'd0);
        chk("t4_frame_done", fd_cnt - fd0, 32'd1);
        ss_on();
        spi_byte(8'h81, 8'hFF);
        ss_off();
        chk("t4_rx_data", {24'd0, rx_data_o}, 32'h81);

        // reset mid-byte
        ss_on();
        spi_bits(8'hC3, 3, junk);
        fd0 = fd_cnt;
        rx0 = rx_cnt;
        HRESETn = 1'b0;
        SPI_SS_i = 1'b1;
        SPI_CLK_i = 1'b0;
        clk_n(2);
        chk("t5_tx_ready", {31'd0, tx_ready_o}, 32'd1);
        chk("t5_rx_valid", {31'd0, rx_valid_o}, 32'd0);
        chk("t5_miso", {31'd0, SPI_MISO_o}, 32'd0);
        chk("t5_oe", {31'd0, SPI_MISO_OE_o}, 32'd0);
        chk("t5_rx_data", {24'd0, rx_data_o}, 32'd0);
        chk("t5_underrun", {31'd0, tx_underrun_o}, 32'd0);
        chk("t5_selected", {31'd0, selected_o}, 32'd0);
        HRESETn = 1'b1;
        clk_n(HALF);
        chk("t5_no_frame_done", fd_cnt - fd0, 32'd0);
        chk("t5_no_rx", rx_cnt - rx0, 32'd0);
        tx_write(8'h5A);
        ss_on();
        spi_byte(8'h55, 8'h5A);
        ss_off();
        chk("t5_rx_data_after", {24'd0, rx_data_o}, 32'h55);

        chk("rx_queue_empty", rx_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
